// File: rtl/zbuf_depth_test_if.sv
// rtl/zbuf_depth_test_if.sv - fragment stream, Z cache lookup/update and stats bundle for zbuf_depth_test
interface zbuf_depth_test_if #(
    parameter int ID_W    = 19,
    parameter int Z_W     = 16,
    parameter int COLOR_W = 24
);
    logic               in_valid;
    logic               in_ready;
    logic [ID_W-1:0]    in_id;
    logic [Z_W-1:0]     in_z;
    logic [COLOR_W-1:0] in_color;
    logic [1:0]         depth_func;
    logic               zwrite_en;
    logic [ID_W-1:0]    frag_id;
    logic               frag_rd_en;
    logic               frag_hit;
    logic [Z_W-1:0]     frag_zval;
    logic [ID_W-1:0]    update_id;
    logic               update_en;
    logic [Z_W-1:0]     update_val;
    logic               update_hit;
    logic               out_valid;
    logic               out_ready;
    logic [ID_W-1:0]    out_id;
    logic [COLOR_W-1:0] out_color;
    logic [31:0]        pass_count;
    logic [31:0]        kill_count;

    modport master (
        output in_valid, in_id, in_z, in_color, depth_func, zwrite_en,
               frag_hit, frag_zval, update_hit, out_ready,
        input  in_ready, frag_id, frag_rd_en, update_id, update_en, update_val,
               out_valid, out_id, out_color, pass_count, kill_count
    );

    modport slave (
        input  in_valid, in_id, in_z, in_color, depth_func, zwrite_en,
               frag_hit, frag_zval, update_hit, out_ready,
        output in_ready, frag_id, frag_rd_en, update_id, update_en, update_val,
               out_valid, out_id, out_color, pass_count, kill_count
    );
endinterface

// File: rtl/zbuf_depth_test.sv
// rtl/zbuf_depth_test.sv - per-fragment depth test stage in front of zbuf_cache
module zbuf_depth_test #(
    parameter int ID_W    = 19,
    parameter int Z_W     = 16,
    parameter int COLOR_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    zbuf_depth_test_if.slave bus
);
    localparam logic [1:0] F_LESS   = 2'b00;
    localparam logic [1:0] F_LEQUAL = 2'b01;
    localparam logic [1:0] F_ALWAYS = 2'b10;
    localparam logic [1:0] F_NEVER  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_COMPARE, S_UPDATE, S_EMIT
    } state_t;

    state_t             state_q, state_d;
    logic               first_q;
    logic [ID_W-1:0]    id_q;
    logic [Z_W-1:0]     z_q;
    logic [Z_W-1:0]     stored_q;
    logic [COLOR_W-1:0] color_q;
    logic [1:0]         func_q;
    logic               zwr_q;
    logic [31:0]        pass_q;
    logic [31:0]        kill_q;

    logic accept;
    logic zpass;
    logic kill_inc;
    logic pass_inc;

    assign accept   = (state_q == S_IDLE) && bus.in_valid;
    assign zpass    = (func_q == F_LESS)   ? (z_q <  stored_q) :
                      (func_q == F_LEQUAL) ? (z_q <= stored_q) : 1'b0;
    assign kill_inc = (accept && bus.depth_func == F_NEVER) ||
                      (state_q == S_COMPARE && !zpass);
    assign pass_inc = (state_q == S_EMIT) && bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (bus.depth_func)
                        F_NEVER:  state_d = S_IDLE;
                        F_ALWAYS: state_d = bus.zwrite_en ? S_UPDATE : S_EMIT;
                        default:  state_d = S_LOOKUP;
                    endcase
                end
            end
            // The hit seen on the first lookup edge may belong to the previous request.
            S_LOOKUP:  if (!first_q && bus.frag_hit) state_d = S_COMPARE;
            S_COMPARE: state_d = zpass ? (zwr_q ? S_UPDATE : S_EMIT) : S_IDLE;
            S_UPDATE:  if (bus.update_hit) state_d = S_EMIT;
            S_EMIT:    if (bus.out_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready   = (state_q == S_IDLE);
        bus.frag_rd_en = (state_q == S_LOOKUP);
        bus.update_en  = (state_q == S_UPDATE);
        bus.out_valid  = (state_q == S_EMIT);
        bus.frag_id    = id_q;
        bus.update_id  = id_q;
        bus.update_val = z_q;
        bus.out_id     = id_q;
        bus.out_color  = color_q;
        bus.pass_count = pass_q;
        bus.kill_count = kill_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_q  <= 1'b1;
            id_q     <= '0;
            z_q      <= '0;
            stored_q <= '0;
            color_q  <= '0;
            func_q   <= '0;
            zwr_q    <= 1'b0;
            pass_q   <= '0;
            kill_q   <= '0;
        end else begin
            first_q <= (state_q != S_LOOKUP);
            if (accept) begin
                id_q    <= bus.in_id;
                z_q     <= bus.in_z;
                color_q <= bus.in_color;
                func_q  <= bus.depth_func;
                zwr_q   <= bus.zwrite_en;
            end
            if (state_q == S_LOOKUP && !first_q && bus.frag_hit) stored_q <= bus.frag_zval;
            if (kill_inc && kill_q != 32'hFFFF_FFFF) kill_q <= kill_q + 32'd1;
            if (pass_inc && pass_q != 32'hFFFF_FFFF) pass_q <= pass_q + 32'd1;
        end
    end
endmodule
